// File: rtl/nvdla_dbb_rd_arbiter_if.sv
// DBB read-path bundle: AR request channel plus R return channel.
// master drives AR and R-ready; slave drives AR-ready and R beats.
interface nvdla_dbb_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 7
);
  logic                  ar_valid;
  logic                  ar_ready;
  logic [3:0]            ar_len;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [ID_WIDTH-1:0]   ar_id;
  logic                  r_valid;
  logic                  r_ready;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_WIDTH-1:0]   r_id;

  modport master (
    output ar_valid, ar_len, ar_addr, ar_id, r_ready,
    input  ar_ready, r_valid, r_last, r_data, r_id
  );

  modport slave (
    input  ar_valid, ar_len, ar_addr, ar_id, r_ready,
    output ar_ready, r_valid, r_last, r_data, r_id
  );
endinterface

// File: rtl/nvdla_dbb_rd_arbiter.sv
// Two-requester round-robin DBB read arbiter with outstanding throttle.
// NVDLA_DBB_RD_ARB_STATS_EN adds per-requester grant/stall counters.
module nvdla_dbb_rd_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk,
  input  logic rst_n,
  nvdla_dbb_rd_arbiter_if.slave  s0,
  nvdla_dbb_rd_arbiter_if.slave  s1,
  nvdla_dbb_rd_arbiter_if.master m,
  output logic s0_busy,
  output logic s1_busy
`ifdef NVDLA_DBB_RD_ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [31:0] s0_grant_cnt,
  output logic [31:0] s0_stall_cnt,
  output logic [31:0] s1_grant_cnt,
  output logic [31:0] s1_stall_cnt
`endif
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  cnt0, cnt1;
  logic                  rr_ptr;
  logic                  ar_valid_q;
  logic [3:0]            ar_len_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]            ar_id_q;

  logic elig0, elig1, win0, win1, slice_free;
  logic acc0, acc1, dec0, dec1, r_sel, r_fire;

  assign elig0      = s0.ar_valid && (cnt0 < CNT_MAX);
  assign elig1      = s1.ar_valid && (cnt1 < CNT_MAX);
  assign slice_free = !ar_valid_q || m.ar_ready;

  // rr_ptr only breaks ties; a lone eligible requester always wins
  assign win0 = elig0 && (!elig1 || !rr_ptr);
  assign win1 = elig1 && (!elig0 || rr_ptr);

  assign s0.ar_ready = slice_free && win0;
  assign s1.ar_ready = slice_free && win1;
  assign acc0 = s0.ar_valid && s0.ar_ready;
  assign acc1 = s1.ar_valid && s1.ar_ready;

  assign m.ar_valid = ar_valid_q;
  assign m.ar_len   = ar_len_q;
  assign m.ar_addr  = ar_addr_q;
  assign m.ar_id    = ar_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_valid_q <= 1'b0;
      ar_len_q   <= '0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      rr_ptr     <= 1'b0;
    end else if (acc0) begin
      ar_valid_q <= 1'b1;
      ar_len_q   <= s0.ar_len;
      ar_addr_q  <= s0.ar_addr;
      ar_id_q    <= {1'b0, s0.ar_id};
      rr_ptr     <= 1'b1;
    end else if (acc1) begin
      ar_valid_q <= 1'b1;
      ar_len_q   <= s1.ar_len;
      ar_addr_q  <= s1.ar_addr;
      ar_id_q    <= {1'b1, s1.ar_id};
      rr_ptr     <= 1'b0;
    end else if (slice_free) begin
      ar_valid_q <= 1'b0;
    end
  end

  assign r_sel  = m.r_id[7];
  assign r_fire = m.r_valid && m.r_ready && m.r_last;
  assign dec0   = r_fire && !r_sel;
  assign dec1   = r_fire && r_sel;

  assign m.r_ready  = r_sel ? s1.r_ready : s0.r_ready;
  assign s0.r_valid = m.r_valid && !r_sel;
  assign s1.r_valid = m.r_valid && r_sel;
  assign s0.r_last  = m.r_last;
  assign s1.r_last  = m.r_last;
  assign s0.r_data  = m.r_data;
  assign s1.r_data  = m.r_data;
  assign s0.r_id    = m.r_id[6:0];
  assign s1.r_id    = m.r_id[6:0];

  // a stray last beat at zero is a DBB protocol error; hold, never wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
    end else if (acc0 && !dec0) begin
      cnt0 <= cnt0 + CNT_ONE;
    end else if (dec0 && !acc0 && cnt0 != '0) begin
      cnt0 <= cnt0 - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
    end else if (acc1 && !dec1) begin
      cnt1 <= cnt1 + CNT_ONE;
    end else if (dec1 && !acc1 && cnt1 != '0) begin
      cnt1 <= cnt1 - CNT_ONE;
    end
  end

  assign s0_busy = (cnt0 != '0);
  assign s1_busy = (cnt1 != '0);

`ifdef NVDLA_DBB_RD_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_grant_cnt <= '0;
      s0_stall_cnt <= '0;
      s1_grant_cnt <= '0;
      s1_stall_cnt <= '0;
    end else if (stats_clr) begin
      s0_grant_cnt <= '0;
      s0_stall_cnt <= '0;
      s1_grant_cnt <= '0;
      s1_stall_cnt <= '0;
    end else begin
      if (acc0) s0_grant_cnt <= s0_grant_cnt + 32'd1;
      if (acc1) s1_grant_cnt <= s1_grant_cnt + 32'd1;
      if (s0.ar_valid && !s0.ar_ready)
        s0_stall_cnt <= s0_stall_cnt + 32'd1;
      if (s1.ar_valid && !s1.ar_ready)
        s1_stall_cnt <= s1_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
